// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/redirect controller.
package pipe_hazard_ctrl_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEQ = 2'd0;
  localparam pc_sel_t PC_BR  = 2'd1;
  localparam pc_sel_t PC_JMP = 2'd2;
  localparam pc_sel_t PC_JR  = 2'd3;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status/control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_ctrl_pkg::*;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_jump;
  logic             ex_memtoreg;
  logic [4:0]       ex_rw;
  logic             me_branch;
  logic             me_zero;
  logic             me_pred_taken;
  logic             me_jr;
  logic             mem_busy;

  logic             pc_en;
  logic             ifid_en;
  pc_sel_t          pc_sel;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             warm;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_rs, id_rt, id_jump, ex_memtoreg, ex_rw,
           me_branch, me_zero, me_pred_taken, me_jr, mem_busy,
    input  pc_en, ifid_en, pc_sel, ifid_flush, idex_flush, exmem_flush,
           warm, stall_count, redirect_count
  );

  modport slave (
    input  id_rs, id_rt, id_jump, ex_memtoreg, ex_rw,
           me_branch, me_zero, me_pred_taken, me_jr, mem_busy,
    output pc_en, ifid_en, pc_sel, ifid_flush, idex_flush, exmem_flush,
           warm, stall_count, redirect_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/redirect controller: load-use interlock, mispredict and jump
// redirects, data-memory freeze, and a counted post-reset warm-up window.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WU_W-1:0] WU_INIT =
    (WARMUP_CYCLES > 0) ? WU_W'(WARMUP_CYCLES - 1) : '0;
  localparam hz_state_e RST_STATE = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

  hz_state_e        state_q, state_d;
  logic [WU_W-1:0]  wu_cnt_q, wu_cnt_d;

  logic             running;
  logic             load_use;
  logic             mispredict;
  logic             stall_inc;
  logic             redir_inc;

  logic             pc_en;
  logic             ifid_en;
  pc_sel_t          pc_sel;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] redirect_count;

  assign running    = (state_q == ST_RUN) || (state_q == ST_BUBBLE);
  assign load_use   = hz.ex_memtoreg && (hz.ex_rw != 5'd0) &&
                      ((hz.ex_rw == hz.id_rs) || (hz.ex_rw == hz.id_rt));
  assign mispredict = hz.me_branch && (hz.me_zero != hz.me_pred_taken);

  always_comb begin
    state_d     = state_q;
    wu_cnt_d    = wu_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pc_sel      = PC_SEQ;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;

    if (!running) begin
      // Warm-up: pipeline free-runs sequentially, every hazard input is ignored.
      if (wu_cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        wu_cnt_d = wu_cnt_q - 1'b1;
      end
    end else if (hz.mem_busy) begin
      // Freeze holds state so a pending redirect or bubble survives the stall.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else begin
      state_d = ST_RUN;
      if (hz.me_jr) begin
        pc_sel      = PC_JR;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        redir_inc   = 1'b1;
      end else if (mispredict) begin
        pc_sel      = PC_BR;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        redir_inc   = 1'b1;
      end else if (load_use && (state_q == ST_RUN)) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        state_d    = ST_BUBBLE;
      end else if (hz.id_jump) begin
        pc_sel     = PC_JMP;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      wu_cnt_q <= WU_INIT;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (redir_inc),
    .clear (1'b0),
    .count (redirect_count)
  );

  assign hz.pc_en          = pc_en;
  assign hz.ifid_en        = ifid_en;
  assign hz.pc_sel         = pc_sel;
  assign hz.ifid_flush     = ifid_flush;
  assign hz.idex_flush     = idex_flush;
  assign hz.exmem_flush    = exmem_flush;
  assign hz.warm           = running;
  assign hz.stall_count    = stall_count;
  assign hz.redirect_count = redirect_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int WARMUP = 4;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int OW     = 8 + 2 * CW;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  // Reference model state
  int   m_warm_left;
  bit   m_bubble;
  int   m_stalls;
  int   m_redirs;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hif();

  pipe_hazard_ctrl #(.WARMUP_CYCLES(WARMUP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OW-1:0] observed();
    return {hif.pc_en, hif.ifid_en, hif.pc_sel, hif.ifid_flush, hif.idex_flush,
            hif.exmem_flush, hif.warm, hif.stall_count, hif.redirect_count};
  endfunction

  function automatic bit m_lu();
    return hif.ex_memtoreg && (hif.ex_rw != 0) &&
           ((hif.ex_rw == hif.id_rs) || (hif.ex_rw == hif.id_rt));
  endfunction

  function automatic bit m_mp();
    return hif.me_branch && (hif.me_zero != hif.me_pred_taken);
  endfunction

  function automatic logic [OW-1:0] expected();
    bit pe = 1'b1, ie = 1'b1, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
    logic [1:0] sel = 2'd0;
    bit w = (m_warm_left == 0);
    if (w) begin
      if (hif.mem_busy) begin
        pe = 1'b0; ie = 1'b0;
      end else if (hif.me_jr) begin
        sel = 2'd3; f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
      end else if (m_mp()) begin
        sel = 2'd1; f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
      end else if (m_lu() && !m_bubble) begin
        pe = 1'b0; ie = 1'b0; f2 = 1'b1;
      end else if (hif.id_jump) begin
        sel = 2'd2; f1 = 1'b1;
      end
    end
    return {pe, ie, sel, f1, f2, f3, w, CW'(m_stalls), CW'(m_redirs)};
  endfunction

  function automatic logic [OW-1:0] reset_outputs();
    return {1'b1, 1'b1, 2'd0, 3'b000, 1'b0, CW'(0), CW'(0)};
  endfunction

  task automatic model_reset();
    m_warm_left = WARMUP;
    m_bubble    = 1'b0;
    m_stalls    = 0;
    m_redirs    = 0;
  endtask

  task automatic model_clock();
    if (m_warm_left > 0) begin
      m_warm_left--;
    end else if (!hif.mem_busy) begin
      if (hif.me_jr || m_mp()) begin
        if (m_redirs < CMAX) m_redirs++;
        m_bubble = 1'b0;
      end else if (m_lu() && !m_bubble) begin
        if (m_stalls < CMAX) m_stalls++;
        m_bubble = 1'b1;
      end else begin
        m_bubble = 1'b0;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_jump = 1'b0;
    hif.ex_memtoreg = 1'b0; hif.ex_rw = 5'd0;
    hif.me_branch = 1'b0; hif.me_zero = 1'b0; hif.me_pred_taken = 1'b0;
    hif.me_jr = 1'b0; hif.mem_busy = 1'b0;
  endtask

  // Entered just after a falling edge with inputs applied; leaves at the next falling edge.
  task automatic tick(string tag);
    #1;
    check(tag, 32'(observed()), 32'(expected()));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    check("reset_vals", 32'(observed()), 32'(reset_outputs()));
    @(negedge clk);
    reset = 1'b0;

    // Warm-up with a JR held: suppressed for WARMUP cycles, then redirect.
    hif.me_jr = 1'b1;
    repeat (WARMUP) tick("warmup");
    #1;
    check("warmup_jr_sel", 32'(hif.pc_sel), 32'd3);
    tick("warmup_jr");
    hif.me_jr = 1'b0;

    // Load-use held for two cycles: exactly one stall.
    hif.ex_memtoreg = 1'b1; hif.ex_rw = 5'd8; hif.id_rt = 5'd8;
    tick("ldu_stall");
    tick("ldu_bubble");
    clear_inputs();
    tick("ldu_after");
    check("ldu_count", 32'(hif.stall_count), 32'd1);

    // Load into r0 never stalls.
    hif.ex_memtoreg = 1'b1; hif.ex_rw = 5'd0; hif.id_rs = 5'd0; hif.id_rt = 5'd0;
    tick("r0_nostall");

    // Mispredict coincident with load-use: mispredict wins, no stall counted.
    hif.ex_memtoreg = 1'b1; hif.ex_rw = 5'd8; hif.id_rt = 5'd8;
    hif.me_branch = 1'b1; hif.me_zero = 1'b1; hif.me_pred_taken = 1'b0;
    tick("mp_vs_ldu");
    clear_inputs();
    check("mp_redir_cnt", 32'(hif.redirect_count), 32'd2);
    check("mp_stall_cnt", 32'(hif.stall_count), 32'd1);

    // JR coincident with mispredict: counted once.
    hif.me_jr = 1'b1; hif.me_branch = 1'b1; hif.me_zero = 1'b0; hif.me_pred_taken = 1'b1;
    tick("jr_vs_mp");
    clear_inputs();
    check("jr_mp_cnt", 32'(hif.redirect_count), 32'd3);

    // Memory freeze over a pending JR, then the redirect on release.
    hif.me_jr = 1'b1; hif.mem_busy = 1'b1;
    repeat (3) tick("freeze");
    hif.mem_busy = 1'b0;
    tick("freeze_release");
    clear_inputs();
    check("freeze_cnt", 32'(hif.redirect_count), 32'd4);

    // J costs a single IF/ID flush.
    hif.id_jump = 1'b1;
    tick("jump");
    clear_inputs();
    tick("idle");

    // 20 load-use events saturate the 4-bit stall counter.
    hif.ex_memtoreg = 1'b1; hif.ex_rw = 5'd5; hif.id_rs = 5'd5;
    repeat (40) tick("sat_ldu");
    clear_inputs();
    check("sat_count", 32'(hif.stall_count), 32'(CMAX));

    // Random traffic with small register numbers to provoke dependencies.
    for (int i = 0; i < 300; i++) begin
      hif.id_rs         = 5'($urandom_range(0, 3));
      hif.id_rt         = 5'($urandom_range(0, 3));
      hif.ex_rw         = 5'($urandom_range(0, 3));
      hif.ex_memtoreg   = 1'($urandom_range(0, 1));
      hif.id_jump       = ($urandom_range(0, 5) == 0);
      hif.me_branch     = ($urandom_range(0, 3) == 0);
      hif.me_zero       = 1'($urandom_range(0, 1));
      hif.me_pred_taken = 1'($urandom_range(0, 1));
      hif.me_jr         = ($urandom_range(0, 9) == 0);
      hif.mem_busy      = ($urandom_range(0, 4) == 0);
      tick("random");
    end
    clear_inputs();

    // Async reset between edges while a load-use bubble sits in EX.
    hif.ex_memtoreg = 1'b1; hif.ex_rw = 5'd8; hif.id_rt = 5'd8;
    tick("pre_rst_stall");
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", 32'(observed()), 32'(reset_outputs()));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (WARMUP + 2) tick("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
